p_cache: RTL

P_CACHE -- requirements
Module: p_cache

---
 rtl/p_cache.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/p_cache.sv
`timescale 1ns/1ps
// p_cache: direct-mapped instruction cache for the fetch stage.
//   LINES lines of LINE_WORDS 16-bit words. Address split: tag | index | offset.
//   A lookup takes exactly one cycle: A is registered on an IDLE edge and the
//   data/tag RAMs are read in the same edge. A miss runs a line fill over the
//   external program-memory port (one word per acked cycle). It then spends one
//   DONE cycle re-reading the RAMs so that the next cycle hits.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   A[15:0]      in   fetch word address from the PC stage
//   flush        in   pulse: invalidate every line
//   I[15:0]      out  instruction word for the address registered last edge (0 unless hit)
//   p_cache_miss out  I not valid, fetch stage must hold
//   mem_req      out  external read request (high for the whole fill)
//   mem_addr     out  external read word address (holds outside a fill)
//   mem_ack      in   mem_data valid, current word accepted
//   mem_data     in   external read data
module p_cache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic        flush,
    output logic [15:0] I,
    output logic        p_cache_miss,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int TAG_W  = 16 - IDX_W - OFF_W;
    localparam int RAM_AW = IDX_W + OFF_W;
    localparam int WORDS  = LINES * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state;
    state_t              state_nxt;

    logic [15:0]         addr_p1;      // registered fetch address (lookup stage)
    logic                vld_p1;       // a lookup has been issued since reset
    logic [LINES-1:0]    valid;
    logic                flush_pend;
    logic [OFF_W-1:0]    cnt;
    logic [OFF_W-1:0]    cnt_inc;
    logic [15-OFF_W:0]   fill_line;    // line address being filled

    logic [15:0]         data_ram [WORDS];
    logic [TAG_W-1:0]    tag_ram  [LINES];
    logic [15:0]         data_rd;
    logic [TAG_W-1:0]    tag_rd;

    logic [TAG_W-1:0]    addr_tag;
    logic [IDX_W-1:0]    addr_idx;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [RAM_AW-1:0]   rd_addr;
    logic                hit;
    logic                lookup_miss;
    logic                fill_wr;
    logic                last_ack;
    logic                do_flush;

    assign addr_tag = addr_p1[15 -: TAG_W];
    assign addr_idx = addr_p1[OFF_W +: IDX_W];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[15-OFF_W -: TAG_W];
    assign cnt_inc  = cnt + OFF_W'(1);

    // Lookup result is only meaningful in IDLE; outside it the read registers
    // hold stale contents.
    assign hit         = (state == IDLE) & vld_p1 & valid[addr_idx] & (tag_rd == addr_tag);
    assign lookup_miss = (state == IDLE) & vld_p1 & ~hit;
    assign fill_wr     = (state == FILL) & mem_ack;
    assign last_ack    = fill_wr & (cnt == '1);
    assign do_flush    = (state == IDLE) & (flush | flush_pend);

    // DONE re-reads the missed address so the line is visible on the next cycle.
    assign rd_addr = (state == DONE) ? addr_p1[RAM_AW-1:0] : A[RAM_AW-1:0];

    assign I = hit ? data_rd : 16'h0000;

    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        p_cache_miss = lookup_miss;
        case (state)
            IDLE: begin
                if (lookup_miss) state_nxt = FILL;
            end
            FILL: begin
                mem_req      = 1'b1;
                p_cache_miss = 1'b1;
                if (last_ack) state_nxt = DONE;
            end
            DONE: begin
                p_cache_miss = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                p_cache_miss = 1'b1;
                state_nxt    = IDLE;
            end
        endcase
    end

    // ---- stage p1: lookup address, fill control, valid bits ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_p1    <= '0;
            vld_p1     <= 1'b0;
            valid      <= '0;
            flush_pend <= 1'b0;
            cnt        <= '0;
            fill_line  <= '0;
            mem_addr   <= '0;
        end else begin
            state <= state_nxt;

            case (state)
                IDLE: begin
                    vld_p1 <= 1'b1;
                    // On a miss the missed address stays in addr_p1 for the
                    // DONE re-read; the fetch stage is holding A anyway.
                    if (lookup_miss) begin
                        fill_line <= addr_p1[15:OFF_W];
                        cnt       <= '0;
                        mem_addr  <= {addr_p1[15:OFF_W], {OFF_W{1'b0}}};
                    end else begin
                        addr_p1 <= A;
                    end
                end
                FILL: begin
                    if (fill_wr) begin
                        cnt <= cnt_inc;
                        // Last word: leave mem_addr on it rather than wrapping.
                        if (!last_ack) mem_addr <= {fill_line, cnt_inc};
                    end
                end
                default: ;
            endcase

            // A flush seen mid-fill is deferred so it also kills the new line.
            if (state == IDLE) flush_pend <= 1'b0;
            else if (flush)    flush_pend <= 1'b1;

            if (do_flush)         valid           <= '0;
            else if (lookup_miss) valid[addr_idx] <= 1'b0;
            else if (last_ack)    valid[fill_idx] <= 1'b1;
        end
    end

    // ---- stage p1: synchronous RAMs (contents survive reset) ----
    always_ff @(posedge clk) begin
        if (fill_wr) data_ram[{fill_idx, cnt}] <= mem_data;
        if (state != FILL) data_rd <= data_ram[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (last_ack) tag_ram[fill_idx] <= fill_tag;
        if (state != FILL) tag_rd <= tag_ram[rd_addr[RAM_AW-1:OFF_W]];
    end

endmodule
